// File: rtl/twi_pkg.sv
// Shared types and constants for the TWI hub.
// Holds the line-arbiter state encoding and the port limits.
package twi_pkg;

  localparam int HOST_IDX  = 0;
  localparam int MAX_PORTS = 8;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_OWNED   = 2'd1,
    ARB_RECOVER = 2'd2
  } arbState_e;

endpackage

// File: rtl/twi_hub_if.sv
// Pin bundle between the TWI hub and the host/mirror buses.
// The bus side drives the levels; the hub drives the pull-lows.
interface twi_hub_if #(
  parameter int N_PORTS = 2
);

  logic               hostSclIn;
  logic               hostSclLow;
  logic               hostSdaIn;
  logic               hostSdaLow;
  logic [N_PORTS-1:0] mirrorSclIn;
  logic [N_PORTS-1:0] mirrorSclLow;
  logic [N_PORTS-1:0] mirrorSdaIn;
  logic [N_PORTS-1:0] mirrorSdaLow;
  logic [N_PORTS-1:0] portEnable;
  logic               stuckErr;

  modport master (
    output hostSclIn,
    output hostSdaIn,
    output mirrorSclIn,
    output mirrorSdaIn,
    output portEnable,
    input  hostSclLow,
    input  hostSdaLow,
    input  mirrorSclLow,
    input  mirrorSdaLow,
    input  stuckErr
  );

  modport slave (
    input  hostSclIn,
    input  hostSdaIn,
    input  mirrorSclIn,
    input  mirrorSdaIn,
    input  portEnable,
    output hostSclLow,
    output hostSdaLow,
    output mirrorSclLow,
    output mirrorSdaLow,
    output stuckErr
  );

endinterface

// File: rtl/twi_line_arb.sv
// One open-drain line arbiter: sync + glitch filter per participant,
// ownership FSM and a bounded recovery timer.
module twi_line_arb
  import twi_pkg::*;
#(
  parameter int NP           = 2,
  parameter int FILT         = 3,
  parameter int STUCK_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [NP:0] lineIn,
  input  logic [NP:0] en,
  output logic [NP:0] lineLow,
  output logic        stuck
);

  localparam int P  = NP + 1;
  localparam int CW = $clog2(FILT + 1);
  localparam int SW = $clog2(STUCK_CYCLES + 1);

  logic [P-1:0]  s1;
  logic [P-1:0]  s2;
  logic [P-1:0]  filt;
  logic [CW-1:0] fcnt [P];

  arbState_e     state;
  arbState_e     stateNxt;
  logic [P-1:0]  owner;
  logic [P-1:0]  ownerNxt;
  logic [P-1:0]  lowNxt;
  logic [SW-1:0] rcnt;
  logic [SW-1:0] rcntNxt;
  logic          stuckNxt;

  logic [P-1:0]  active;
  logic [P-1:0]  pick;
  logic          quiet;

  // filter flips only after FILT consecutive opposite samples
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= '1;
      s2   <= '1;
      filt <= '1;
      for (int i = 0; i < P; i++) fcnt[i] <= '0;
    end else begin
      s1 <= lineIn;
      s2 <= s1;
      for (int i = 0; i < P; i++) begin
        if (s2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == CW'(FILT - 1)) begin
          filt[i] <= s2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  // lowest set bit wins, so the host (bit 0) beats every mirror
  assign active = en & ~filt;
  assign pick   = active & (~active + P'(1));
  assign quiet  = &(filt | ~en);

  always_comb begin
    stateNxt = state;
    ownerNxt = owner;
    lowNxt   = '0;
    rcntNxt  = rcnt;
    stuckNxt = stuck;
    unique case (state)
      ARB_IDLE: begin
        if (|active) begin
          stateNxt = ARB_OWNED;
          ownerNxt = pick;
          lowNxt   = en & ~pick;
        end
      end
      ARB_OWNED: begin
        if (|(owner & (filt | ~en))) begin
          stateNxt = ARB_RECOVER;
          rcntNxt  = '0;
        end else begin
          lowNxt = en & ~owner;
        end
      end
      ARB_RECOVER: begin
        if (quiet) begin
          stateNxt = ARB_IDLE;
        end else if (rcnt == SW'(STUCK_CYCLES - 1)) begin
          stateNxt = ARB_IDLE;
          stuckNxt = 1'b1;
        end else if (rcnt != '1) begin
          rcntNxt = rcnt + 1'b1;
        end
      end
      default: stateNxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB_IDLE;
      owner   <= '0;
      lineLow <= '0;
      rcnt    <= '0;
      stuck   <= 1'b0;
    end else begin
      state   <= stateNxt;
      owner   <= ownerNxt;
      lineLow <= lowNxt;
      rcnt    <= rcntNxt;
      stuck   <= stuckNxt;
    end
  end

endmodule

// File: rtl/twi_hub.sv
// TWI hub: mirrors one host I2C bus onto N_PORTS mirror buses,
// with one independent arbiter each for SCL and SDA.
module twi_hub
  import twi_pkg::*;
#(
  parameter int N_PORTS      = 2,
  parameter int FILT         = 3,
  parameter int STUCK_CYCLES = 65535
) (
  input logic       clk,
  input logic       rst,
  twi_hub_if.slave  bus
);

  if (N_PORTS < 1 || N_PORTS > MAX_PORTS) begin : gBadPorts
    $error("twi_hub: N_PORTS out of range");
  end

  logic [N_PORTS:0] enAll;
  logic [N_PORTS:0] sclLow;
  logic [N_PORTS:0] sdaLow;
  logic             sclStuck;
  logic             sdaStuck;

  // the host is always a participant
  always_comb begin
    enAll           = {bus.portEnable, 1'b0};
    enAll[HOST_IDX] = 1'b1;
  end

  twi_line_arb #(
    .NP           (N_PORTS),
    .FILT         (FILT),
    .STUCK_CYCLES (STUCK_CYCLES)
  ) uScl (
    .clk     (clk),
    .rst     (rst),
    .lineIn  ({bus.mirrorSclIn, bus.hostSclIn}),
    .en      (enAll),
    .lineLow (sclLow),
    .stuck   (sclStuck)
  );

  twi_line_arb #(
    .NP           (N_PORTS),
    .FILT         (FILT),
    .STUCK_CYCLES (STUCK_CYCLES)
  ) uSda (
    .clk     (clk),
    .rst     (rst),
    .lineIn  ({bus.mirrorSdaIn, bus.hostSdaIn}),
    .en      (enAll),
    .lineLow (sdaLow),
    .stuck   (sdaStuck)
  );

  assign bus.hostSclLow   = sclLow[HOST_IDX];
  assign bus.mirrorSclLow = sclLow[N_PORTS:1];
  assign bus.hostSdaLow   = sdaLow[HOST_IDX];
  assign bus.mirrorSdaLow = sdaLow[N_PORTS:1];
  assign bus.stuckErr     = sclStuck | sdaStuck;

endmodule

// File: tb/tb_twi_hub.sv
// Bench for twi_hub: directed scenarios plus random pin activity,
// each cycle compared with a window-based behavioural model.
module tb_twi_hub;
  import twi_pkg::*;

  localparam int NP = 3;
  localparam int P  = NP + 1;
  localparam int FL = 2;
  localparam int SC = 16;
  localparam int HD = FL + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  twi_hub_if #(.N_PORTS(NP)) bus ();

  twi_hub #(
    .N_PORTS      (NP),
    .FILT         (FL),
    .STUCK_CYCLES (SC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nChecks = 0;
  int nFail   = 0;

  // model: pin history window, filtered level, arbiter bookkeeping
  bit         mHist  [2][P][HD];
  bit         mFilt  [2][P];
  int         mState [2];
  int         mOwner [2];
  int         mDwell [2];
  bit [P-1:0] mLow   [2];
  bit         mStuck;

  function automatic bit pinOf(int ln, int p);
    if (ln == 0) return (p == 0) ? bus.hostSclIn : bus.mirrorSclIn[p-1];
    return (p == 0) ? bus.hostSdaIn : bus.mirrorSdaIn[p-1];
  endfunction

  function automatic bit enOf(int p);
    return (p == 0) ? 1'b1 : bus.portEnable[p-1];
  endfunction

  task automatic modelEdge();
    if (rst) begin
      mStuck = 0;
      for (int ln = 0; ln < 2; ln++) begin
        mState[ln] = 0;
        mOwner[ln] = 0;
        mDwell[ln] = 0;
        mLow[ln]   = '0;
        for (int p = 0; p < P; p++) begin
          mFilt[ln][p] = 1;
          for (int a = 0; a < HD; a++) mHist[ln][p][a] = 1;
        end
      end
      return;
    end
    for (int ln = 0; ln < 2; ln++) begin
      bit [P-1:0] nl;
      nl = '0;
      if (mState[ln] == 0) begin
        int win;
        win = -1;
        for (int p = P - 1; p >= 0; p--)
          if (enOf(p) && !mFilt[ln][p]) win = p;
        if (win >= 0) begin
          mState[ln] = 1;
          mOwner[ln] = win;
          for (int q = 0; q < P; q++) nl[q] = enOf(q) && (q != win);
        end
      end else if (mState[ln] == 1) begin
        if (mFilt[ln][mOwner[ln]] || !enOf(mOwner[ln])) begin
          mState[ln] = 2;
          mDwell[ln] = 1;
        end else begin
          for (int q = 0; q < P; q++) nl[q] = enOf(q) && (q != mOwner[ln]);
        end
      end else begin
        bit allHigh;
        allHigh = 1;
        for (int p = 0; p < P; p++)
          if (enOf(p) && !mFilt[ln][p]) allHigh = 0;
        if (allHigh) begin
          mState[ln] = 0;
        end else if (mDwell[ln] >= SC) begin
          mState[ln] = 0;
          mStuck = 1;
        end else begin
          mDwell[ln]++;
        end
      end
      mLow[ln] = nl;
    end
    // filtered level takes a value once the last FL synced samples all show it
    for (int ln = 0; ln < 2; ln++) begin
      for (int p = 0; p < P; p++) begin
        bit allOpp;
        allOpp = 1;
        for (int a = 1; a <= FL; a++)
          if (mHist[ln][p][a] == mFilt[ln][p]) allOpp = 0;
        if (allOpp) mFilt[ln][p] = ~mFilt[ln][p];
        for (int a = HD - 1; a >= 1; a--) mHist[ln][p][a] = mHist[ln][p][a-1];
        mHist[ln][p][0] = pinOf(ln, p);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic stChk(input string tag, input int ln,
                       input arbState_e exp);
    arbState_e obs;
    obs = (ln == 0) ? dut.uScl.state : dut.uSda.state;
    chk(tag, 32'(obs), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
    chk("mdlScl", 32'({bus.mirrorSclLow, bus.hostSclLow}), 32'(mLow[0]));
    chk("mdlSda", 32'({bus.mirrorSdaLow, bus.hostSdaLow}), 32'(mLow[1]));
    chk("mdlStuck", 32'(bus.stuckErr), 32'(mStuck));
  endtask

  task automatic setPin(input int ln, input int p, input logic v);
    if (ln == 0) begin
      if (p == 0) bus.hostSclIn = v;
      else        bus.mirrorSclIn[p-1] = v;
    end else begin
      if (p == 0) bus.hostSdaIn = v;
      else        bus.mirrorSdaIn[p-1] = v;
    end
  endtask

  task automatic allHigh();
    bus.hostSclIn   = 1'b1;
    bus.hostSdaIn   = 1'b1;
    bus.mirrorSclIn = '1;
    bus.mirrorSdaIn = '1;
  endtask

  initial begin
    allHigh();
    bus.portEnable = 3'b111;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rstSdaLow", 32'({bus.mirrorSdaLow, bus.hostSdaLow}), 0);
    chk("rstSclLow", 32'({bus.mirrorSclLow, bus.hostSclLow}), 0);
    chk("rstStuck", 32'(bus.stuckErr), 0);
    stChk("rstStSda", 1, ARB_IDLE);
    repeat (2) tick();

    // host SDA falls: mirrors pulled 5 cycles later
    bus.hostSdaIn = 1'b0;
    repeat (4) tick();
    chk("hostEarly", 32'(bus.mirrorSdaLow), 0);
    tick();
    chk("hostMirLow", 32'(bus.mirrorSdaLow), 3'b111);
    chk("hostOwnLow", 32'(bus.hostSdaLow), 0);
    bus.hostSdaIn = 1'b1;
    repeat (8) tick();

    // mirror 1 owns SDA
    bus.mirrorSdaIn[1] = 1'b0;
    repeat (5) tick();
    chk("m1HostLow", 32'(bus.hostSdaLow), 1);
    chk("m1MirLow", 32'(bus.mirrorSdaLow), 3'b101);
    bus.mirrorSdaIn[1] = 1'b1;
    repeat (4) tick();
    chk("m1Hold", 32'(bus.mirrorSdaLow), 3'b101);
    tick();
    chk("m1Rel", 32'({bus.mirrorSdaLow, bus.hostSdaLow}), 0);
    repeat (6) tick();

    // simultaneous host and mirror 0: host wins
    bus.hostSdaIn      = 1'b0;
    bus.mirrorSdaIn[0] = 1'b0;
    repeat (5) tick();
    chk("tieMir", 32'(bus.mirrorSdaLow), 3'b111);
    chk("tieHost", 32'(bus.hostSdaLow), 0);
    allHigh();
    repeat (8) tick();

    // one-cycle glitch is swallowed
    bus.hostSdaIn = 1'b0;
    tick();
    bus.hostSdaIn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("glitchLow", 32'({bus.mirrorSdaLow, bus.hostSdaLow}), 0);
      stChk("glitchSt", 1, ARB_IDLE);
    end

    // stuck mirror 2 on SCL after host releases
    bus.hostSclIn      = 1'b0;
    bus.mirrorSclIn[2] = 1'b0;
    repeat (5) tick();
    chk("stkOwn", 32'(bus.mirrorSclLow), 3'b111);
    bus.hostSclIn = 1'b1;
    repeat (5) tick();
    stChk("stkRec0", 0, ARB_RECOVER);
    chk("stkRelLow", 32'({bus.mirrorSclLow, bus.hostSclLow}), 0);
    for (int i = 0; i < SC - 1; i++) begin
      tick();
      stChk("stkRec", 0, ARB_RECOVER);
    end
    chk("stkNotYet", 32'(bus.stuckErr), 0);
    tick();
    stChk("stkIdle", 0, ARB_IDLE);
    chk("stkErr", 32'(bus.stuckErr), 1);
    tick();
    chk("stkReHost", 32'(bus.hostSclLow), 1);
    chk("stkReMir", 32'(bus.mirrorSclLow), 3'b011);
    bus.mirrorSclIn[2] = 1'b1;
    repeat (8) tick();
    chk("stkSticky", 32'(bus.stuckErr), 1);

    // reset mid-transfer releases, then re-arbitrates
    bus.hostSclIn = 1'b0;
    repeat (5) tick();
    chk("midOwn", 32'(bus.mirrorSclLow), 3'b111);
    rst = 1'b1;
    tick();
    chk("midRst", 32'({bus.mirrorSclLow, bus.hostSclLow}), 0);
    chk("midStuck", 32'(bus.stuckErr), 0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("midWait", 32'(bus.mirrorSclLow), 0);
    tick();
    chk("midReOwn", 32'(bus.mirrorSclLow), 3'b111);
    bus.hostSclIn = 1'b1;
    repeat (8) tick();

    // enabling a port while owned drives it next cycle
    bus.portEnable = 3'b011;
    bus.hostSdaIn  = 1'b0;
    repeat (5) tick();
    chk("enPart", 32'(bus.mirrorSdaLow), 3'b011);
    bus.portEnable = 3'b111;
    tick();
    chk("enFull", 32'(bus.mirrorSdaLow), 3'b111);
    bus.hostSdaIn = 1'b1;
    repeat (8) tick();

    // disabling the owning mirror forces recovery
    bus.mirrorSdaIn[0] = 1'b0;
    repeat (5) tick();
    chk("disOwnH", 32'(bus.hostSdaLow), 1);
    chk("disOwnM", 32'(bus.mirrorSdaLow), 3'b110);
    bus.portEnable[0] = 1'b0;
    tick();
    chk("disHost", 32'(bus.hostSdaLow), 0);
    chk("disMir", 32'(bus.mirrorSdaLow), 0);
    stChk("disRec", 1, ARB_RECOVER);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      stChk("disIgn", 1, ARB_IDLE);
      chk("disIgnLow", 32'({bus.mirrorSdaLow, bus.hostSdaLow}), 0);
    end
    bus.mirrorSdaIn[0] = 1'b1;
    repeat (6) tick();
    bus.portEnable = 3'b111;

    // random pin, enable and reset activity against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 11) == 0) begin
        int ln;
        int p;
        ln = int'($urandom_range(0, 1));
        p  = int'($urandom_range(0, P - 1));
        setPin(ln, p, ~pinOf(ln, p));
      end
      if ($urandom_range(0, 149) == 0)
        bus.portEnable = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
